sha256_mem_responder: RTL and testbench

SHA256_MEM_RESPONDER -- requirements
Module: sha256_mem_responder

---
 rtl/sha256_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_sha256_mem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_mem_responder.sv
// sha256_mem_responder
// Memory-side responder for a SHA-256 core under test. It preloads the
// message words, launches the core with a one-cycle start pulse, serves the
// core's bus (message window read-only, digest window read/write), then
// compares the written digest against the expected value.
// Optional feature: define SHA_RESP_TIMEOUT_EN to abort a run that exceeds
// TIMEOUT_CYCLES cycles after ARM and report result_timeout.
module sha256_mem_responder #(
   parameter int NUM_OF_WORDS   = 20,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [15:0]  message_addr,
   input  logic [15:0]  output_addr,
   input  logic         load_valid,
   input  logic [31:0]  load_data,
   output logic         load_ready,
   input  logic [255:0] expected,
   input  logic         clear,
   output logic         start,
   input  logic         done,
   input  logic         mem_we,
   input  logic [15:0]  mem_addr,
   input  logic [31:0]  mem_write_data,
   output logic [31:0]  mem_read_data,
   output logic         result_valid,
   output logic         result_match,
   output logic         result_err,
   output logic         result_timeout
);

   localparam int CNT_W = (NUM_OF_WORDS > 1) ? $clog2(NUM_OF_WORDS) : 1;

   typedef enum logic [2:0] {LOAD, ARM, RUN, CHECK, REPORT} state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [CNT_W-1:0]   r_loadCnt;
   logic [31:0]        r_msg [NUM_OF_WORDS];
   logic [31:0]        r_digest [8];
   logic [7:0]         r_writtenMask;
   logic               r_busySeen;
   logic               r_err;
   logic               r_match;
   logic [31:0]        r_readData;
   logic [15:0]        w_msgOff;
   logic [15:0]        w_digOff;
   logic               w_inMsg;
   logic               w_inDig;
   logic               w_loadFire;
   logic               w_lastWord;
   logic               w_timeoutHit;
   logic [255:0]       w_digestFlat;

   // Window offsets; the >= test keeps addresses below a base from wrapping in
   assign w_msgOff   = mem_addr - message_addr;
   assign w_digOff   = mem_addr - output_addr;
   assign w_inMsg    = (mem_addr >= message_addr) && (w_msgOff < 16'(NUM_OF_WORDS));
   assign w_inDig    = (mem_addr >= output_addr) && (w_digOff < 16'd8);
   assign w_loadFire = (r_state == LOAD) && load_valid;
   assign w_lastWord = (r_loadCnt == CNT_W'(NUM_OF_WORDS - 1));
   assign mem_read_data = r_readData;

`ifdef SHA_RESP_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_cycleCnt;
   logic            r_timeout;

   assign w_timeoutHit = (r_state == RUN) && (r_cycleCnt >= TO_W'(TIMEOUT_CYCLES - 1));

   // Cycle counter starting in ARM; the ARM cycle counts as cycle zero
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cycleCnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         if (r_state == ARM)
            r_cycleCnt <= TO_W'(1);
         else if (r_state == RUN)
            r_cycleCnt <= r_cycleCnt + 1'b1;
         if (w_timeoutHit)
            r_timeout <= 1'b1;
         else if ((r_state == REPORT) && clear)
            r_timeout <= 1'b0;
      end
   end
`else
   logic w_unusedTimeout;
   assign w_timeoutHit    = 1'b0;
   assign w_unusedTimeout = (TIMEOUT_CYCLES != 0);
`endif

   // Flatten the digest words into {h0..h7} order for the final compare
   always_comb begin
      w_digestFlat = '0;
      for (int i = 0; i < 8; i++)
         w_digestFlat[255 - 32*i -: 32] = r_digest[i];
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      w_nextState    = r_state;
      load_ready     = 1'b0;
      start          = 1'b0;
      result_valid   = 1'b0;
      result_match   = 1'b0;
      result_err     = 1'b0;
      result_timeout = 1'b0;
      case (r_state)
         LOAD: begin
            load_ready = 1'b1;
            if (w_loadFire && w_lastWord)
               w_nextState = ARM;
         end
         ARM: begin
            start       = 1'b1;
            w_nextState = RUN;
         end
         RUN: begin
            if (done && r_busySeen)
               w_nextState = CHECK;
            else if (w_timeoutHit)
               w_nextState = REPORT;
         end
         CHECK: w_nextState = REPORT;
         REPORT: begin
            result_valid = 1'b1;
            result_match = r_match;
            result_err   = r_err;
`ifdef SHA_RESP_TIMEOUT_EN
            result_timeout = r_timeout;
`endif
            if (clear)
               w_nextState = LOAD;
         end
         default: w_nextState = LOAD;
      endcase
   end

   // Message storage; contents survive reset and clear
   always_ff @(posedge clk) begin
      if (w_loadFire)
         r_msg[r_loadCnt] <= load_data;
   end

   // State register, bus servicing, digest capture and result flags
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= LOAD;
         r_loadCnt     <= '0;
         r_writtenMask <= '0;
         r_busySeen    <= 1'b0;
         r_err         <= 1'b0;
         r_match       <= 1'b0;
         r_readData    <= '0;
         for (int i = 0; i < 8; i++)
            r_digest[i] <= '0;
      end else begin
         r_state    <= w_nextState;
         r_readData <= '0;
         case (r_state)
            LOAD: begin
               if (w_loadFire)
                  r_loadCnt <= w_lastWord ? '0 : r_loadCnt + 1'b1;
            end
            RUN: begin
               if (!done)
                  r_busySeen <= 1'b1;
               if (w_inMsg)
                  r_readData <= r_msg[w_msgOff[CNT_W-1:0]];
               else if (w_inDig)
                  r_readData <= r_digest[w_digOff[2:0]];
               if (mem_we) begin
                  if (w_inDig) begin
                     r_digest[w_digOff[2:0]]      <= mem_write_data;
                     r_writtenMask[w_digOff[2:0]] <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            CHECK: begin
               r_match <= (r_writtenMask == 8'hFF) && (w_digestFlat == expected) && !r_err;
            end
            REPORT: begin
               if (clear) begin
                  r_loadCnt     <= '0;
                  r_writtenMask <= '0;
                  r_busySeen    <= 1'b0;
                  r_err         <= 1'b0;
                  r_match       <= 1'b0;
                  for (int i = 0; i < 8; i++)
                     r_digest[i] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_mem_responder.sv
// tb_sha256_mem_responder
// Directed bench: the stimulus pushes expected read data and expected
// results into queues, a forked monitor pops and compares them whenever the
// DUT presents read data or raises result_valid.
module tb_sha256_mem_responder;

   localparam int NW      = 20;
   localparam int TO      = 100;
   localparam int OP_LOAD  = 0;
   localparam int OP_READ  = 1;
   localparam int OP_WRITE = 2;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [15:0]  message_addr;
   logic [15:0]  output_addr;
   logic         load_valid;
   logic [31:0]  load_data;
   logic         load_ready;
   logic [255:0] expected;
   logic         clear;
   logic         start;
   logic         done;
   logic         mem_we;
   logic [15:0]  mem_addr;
   logic [31:0]  mem_write_data;
   logic [31:0]  mem_read_data;
   logic         result_valid;
   logic         result_match;
   logic         result_err;
   logic         result_timeout;

   exp_t        rdQ[$];
   exp_t        resQ[$];
   int          assertCount = 0;
   int          failCount = 0;
   logic        rdReq = 1'b0;
   logic [31:0] hWord [8];

   sha256_mem_responder #(.NUM_OF_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .message_addr(message_addr), .output_addr(output_addr),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .expected(expected), .clear(clear),
      .start(start), .done(done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data),
      .result_valid(result_valid), .result_match(result_match),
      .result_err(result_err), .result_timeout(result_timeout)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
      assertCount++;
      if (actual !== want) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, want);
      end
   endtask

   task automatic reportFail(input string name);
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: got event missing or unexpected, expected scoreboard agreement", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one load word, one bus read or one bus write for a single cycle
   task automatic applyStimulus(input int op, input logic [15:0] addr, input logic [31:0] data, input string name);
      case (op)
         OP_LOAD: begin
            load_valid = 1'b1;
            load_data  = data;
            tick();
            load_valid = 1'b0;
         end
         OP_READ: begin
            mem_addr = addr;
            rdQ.push_back('{name, data});
            rdReq = 1'b1;
            tick();
            rdReq = 1'b0;
         end
         default: begin
            mem_we         = 1'b1;
            mem_addr       = addr;
            mem_write_data = data;
            tick();
            mem_we = 1'b0;
         end
      endcase
   endtask

   // Preload NW words base..base+NW-1; returns in the ARM cycle
   task automatic loadMessage(input logic [31:0] base);
      for (int i = 0; i < NW; i++)
         applyStimulus(OP_LOAD, 16'h0, base + 32'(i), "load");
   endtask

   task automatic writeDigest(input int count);
      for (int i = 0; i < count; i++)
         applyStimulus(OP_WRITE, 16'h0300 + 16'(i), hWord[i], "wr");
   endtask

   task automatic waitResult(input string name);
      int n;
      n = 0;
      while (!result_valid && n < 200) begin
         tick();
         n++;
      end
      if (!result_valid)
         reportFail({name, "_wait"});
   endtask

   task automatic clearResult();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Monitor: compares registered read data and each new result
   task automatic monitorLoop();
      logic sampledRd;
      logic prevValid;
      exp_t e;
      prevValid = 1'b0;
      forever begin
         @(posedge clk);
         sampledRd = rdReq;
         @(negedge clk);
         if (sampledRd) begin
            if (rdQ.size() == 0) reportFail("rd_unexpected");
            else begin
               e = rdQ.pop_front();
               checkOutput(e.name, mem_read_data, e.value);
            end
         end
         if (result_valid && !prevValid) begin
            if (resQ.size() == 0) reportFail("result_unexpected");
            else begin
               e = resQ.pop_front();
               checkOutput({e.name, "_match"}, 32'(result_match), 32'(e.value[2]));
               checkOutput({e.name, "_err"}, 32'(result_err), 32'(e.value[1]));
               checkOutput({e.name, "_timeout"}, 32'(result_timeout), 32'(e.value[0]));
            end
         end
         prevValid = result_valid;
      end
   endtask

   // Main directed sequence
   initial begin
      hWord[0] = 32'h6A09E667; hWord[1] = 32'hBB67AE85;
      hWord[2] = 32'h3C6EF372; hWord[3] = 32'hA54FF53A;
      hWord[4] = 32'h510E527F; hWord[5] = 32'h9B05688C;
      hWord[6] = 32'h1F83D9AB; hWord[7] = 32'h5BE0CD19;
      for (int i = 0; i < 8; i++)
         expected[255 - 32*i -: 32] = hWord[i];
      reset_n = 1'b0; message_addr = 16'h0100; output_addr = 16'h0300;
      load_valid = 1'b0; load_data = '0; clear = 1'b0; done = 1'b1;
      mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
      fork
         monitorLoop();
      join_none
      tick(); tick();
      reset_n = 1'b1;
      checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
      checkOutput("rst_start", 32'(start), 32'd0);
      checkOutput("rst_valid", 32'(result_valid), 32'd0);
      checkOutput("rst_rdata", mem_read_data, 32'h0);

      // Test 1: good run
      $display("[TB] test 1: matching digest");
      loadMessage(32'h1);
      checkOutput("load_ready_after_20", 32'(load_ready), 32'd0);
      checkOutput("start_pulse", 32'(start), 32'd1);
      tick();
      checkOutput("start_one_cycle", 32'(start), 32'd0);
      applyStimulus(OP_READ, 16'h0105, 32'h6, "rd_0105");
      applyStimulus(OP_READ, 16'h0200, 32'h0, "rd_0200");
      applyStimulus(OP_READ, 16'h0100, 32'h1, "rd_msg_first");
      applyStimulus(OP_READ, 16'h0113, 32'h14, "rd_msg_last");
      applyStimulus(OP_READ, 16'h0114, 32'h0, "rd_msg_past");
      applyStimulus(OP_READ, 16'h00FF, 32'h0, "rd_msg_below");
      clear = 1'b1; load_valid = 1'b1; load_data = 32'hDEADBEEF;
      tick();
      clear = 1'b0; load_valid = 1'b0;
      checkOutput("clear_ignored_run", 32'(result_valid), 32'd0);
      done = 1'b0;
      writeDigest(8);
      applyStimulus(OP_READ, 16'h0307, hWord[7], "rd_digest_back");
      applyStimulus(OP_READ, 16'h0100, 32'h1, "rd_load_ignored");
      resQ.push_back('{"t1", 32'b100});
      done = 1'b1;
      waitResult("t1");
      tick(); tick();
      checkOutput("t1_valid_held", 32'(result_valid), 32'd1);
      checkOutput("t1_match_held", 32'(result_match), 32'd1);
      clearResult();
      checkOutput("t1_clear_load_ready", 32'(load_ready), 32'd1);
      checkOutput("t1_clear_valid", 32'(result_valid), 32'd0);

      // Test 2: one digest word missing
      $display("[TB] test 2: incomplete digest");
      loadMessage(32'h100);
      tick();
      applyStimulus(OP_READ, 16'h0300, 32'h0, "rd_digest_cleared");
      applyStimulus(OP_READ, 16'h0105, 32'h105, "rd_reloaded");
      done = 1'b0;
      writeDigest(7);
      resQ.push_back('{"t2", 32'b000});
      done = 1'b1;
      waitResult("t2");
      clearResult();

      // Test 3: stray write outside the digest window
      $display("[TB] test 3: stray write");
      loadMessage(32'h1);
      tick();
      done = 1'b0;
      writeDigest(8);
      applyStimulus(OP_WRITE, 16'h0400, hWord[0], "wr_stray");
      applyStimulus(OP_READ, 16'h0400, 32'h0, "rd_stray");
      resQ.push_back('{"t3", 32'b010});
      done = 1'b1;
      waitResult("t3");
      clearResult();

`ifdef SHA_RESP_TIMEOUT_EN
      // Test 4: core never goes busy, run times out
      $display("[TB] test 4: timeout");
      loadMessage(32'h1);
      resQ.push_back('{"t4", 32'b001});
      for (int k = 1; k < TO; k++)
         tick();
      checkOutput("timeout_not_early", 32'(result_valid), 32'd0);
      tick();
      checkOutput("timeout_at_limit", 32'(result_valid), 32'd1);
      clearResult();
`endif

      // Test 5: reset in the middle of a run
      $display("[TB] test 5: reset mid-run");
      loadMessage(32'h1);
      tick();
      done = 1'b0;
      applyStimulus(OP_READ, 16'h0105, 32'h6, "rd_before_reset");
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      done = 1'b1;
      checkOutput("mid_rst_load_ready", 32'(load_ready), 32'd1);
      checkOutput("mid_rst_start", 32'(start), 32'd0);
      checkOutput("mid_rst_rdata", mem_read_data, 32'h0);
      checkOutput("mid_rst_valid", 32'(result_valid), 32'd0);
      checkOutput("mid_rst_flags", {29'd0, result_match, result_err, result_timeout}, 32'd0);

      tick(); tick(); tick();
      if (rdQ.size() != 0) reportFail("rd_queue_pending");
      if (resQ.size() != 0) reportFail("result_queue_pending");
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
